// File: rtl/core_pkg.sv
// Shared definitions for the core's pipeline control blocks.
//   mc_state_t : sequencing state of the multi-cycle EXE unit handshake
//   REG_ZERO   : hard-wired zero integer register address
package core_pkg;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_RUN  = 2'd1,
        MC_HOLD = 2'd2
    } mc_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently in EXE, for both the integer and the FP register file.
// Ports:
//   rs1_addr/rs2_addr   ID source addresses
//   rs1_is_f/rs2_is_f   source reads the FP file
//   use_rs1/use_rs2     source is actually read
//   rd_addr             EXE destination address
//   mem_read            EXE instruction is a load
//   reg_write           EXE writes the integer file
//   f_reg_write         EXE writes the FP file
//   lu                  load-use hazard present
module load_use_detect
    import core_pkg::*;
(
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic       rs1_is_f,
    input  logic       rs2_is_f,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [4:0] rd_addr,
    input  logic       mem_read,
    input  logic       reg_write,
    input  logic       f_reg_write,
    output logic       lu
);

    logic int_ld;
    logic fp_ld;
    logic hit1;
    logic hit2;

    always_comb begin
        int_ld = mem_read & reg_write & (rd_addr != REG_ZERO);
        // f0 is an ordinary register, so no zero-address exclusion on the FP side
        fp_ld  = mem_read & f_reg_write;
        hit1   = use_rs1 & (rs1_addr == rd_addr) & (rs1_is_f ? fp_ld : int_ld);
        hit2   = use_rs2 & (rs2_addr == rd_addr) & (rs2_is_f ? fp_ld : int_ld);
        lu     = hit1 | hit2;
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage int+FP core.
// Handles load-use, taken-branch flush, memory-wait freeze and sequences the
// multi-cycle EXE unit through a start/done handshake.
// Ports:
//   clk, rst                      clock, async active-high reset
//   id_*                          ID-stage source operand info
//   exe_*                         EXE-stage instruction info
//   imem_stall, dmem_stall        memory not ready (freeze)
//   mc_done                       multi-cycle result valid
//   mc_start                      one-cycle start pulse to the multi-cycle unit
//   *_stall, *_flush, *_bubble    per-stage pipeline register controls
//   mc_timeout                    sticky: forced multi-cycle release occurred
//   perf_stall_cnt                count of cycles with pc_stall=1 (wrapping)
module hazard_stall_ctrl
    import core_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_is_f,
    input  logic             id_rs2_is_f,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       exe_rd_addr,
    input  logic             exe_mem_read,
    input  logic             exe_reg_write,
    input  logic             exe_f_reg_write,
    input  logic             exe_is_mc,
    input  logic             exe_br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             mc_done,
    output logic             mc_start,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_exe_stall,
    output logic             exe_mem_stall,
    output logic             mem_wb_stall,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             exe_mem_bubble,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    localparam int MCC_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [MCC_W-1:0] MC_MAX = MCC_W'(MC_TIMEOUT);

    mc_state_t        state;
    mc_state_t        next_state;
    logic [MCC_W-1:0] mc_cnt;
    logic             lu;
    logic             mem_frz;
    logic             cnt_max;
    logic             release_mc;
    logic             mc_hold;

    load_use_detect u_lu (
        .rs1_addr    (id_rs1_addr),
        .rs2_addr    (id_rs2_addr),
        .rs1_is_f    (id_rs1_is_f),
        .rs2_is_f    (id_rs2_is_f),
        .use_rs1     (id_use_rs1),
        .use_rs2     (id_use_rs2),
        .rd_addr     (exe_rd_addr),
        .mem_read    (exe_mem_read),
        .reg_write   (exe_reg_write),
        .f_reg_write (exe_f_reg_write),
        .lu          (lu)
    );

    always_comb begin
        mem_frz        = imem_stall | dmem_stall;
        cnt_max        = (mc_cnt == MC_MAX);
        release_mc     = (state == MC_RUN) & (mc_done | cnt_max);
        mc_hold        = ((state == MC_RUN) & ~release_mc) |
                         ((state == MC_IDLE) & exe_is_mc);
        next_state     = state;
        mc_start       = 1'b0;
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        id_exe_stall   = 1'b0;
        exe_mem_stall  = 1'b0;
        mem_wb_stall   = 1'b0;
        if_id_flush    = 1'b0;
        id_exe_flush   = 1'b0;
        exe_mem_bubble = 1'b0;

        if (!rst) begin
            mc_start = (state == MC_IDLE) & exe_is_mc & ~mem_frz;

            if (mem_frz) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_exe_stall  = 1'b1;
                exe_mem_stall = 1'b1;
                mem_wb_stall  = 1'b1;
            end else if (mc_hold) begin
                pc_stall       = 1'b1;
                if_id_stall    = 1'b1;
                id_exe_stall   = 1'b1;
                exe_mem_bubble = 1'b1;
            end else if (exe_br_taken) begin
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
            end else if (lu) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_exe_flush = 1'b1;
            end

            case (state)
                MC_IDLE: if (mc_start)   next_state = MC_RUN;
                MC_RUN:  if (release_mc) next_state = mem_frz ? MC_HOLD : MC_IDLE;
                MC_HOLD: if (!mem_frz)   next_state = MC_IDLE;
                default: next_state = MC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= MC_IDLE;
            mc_cnt         <= '0;
            mc_timeout     <= 1'b0;
            perf_stall_cnt <= '0;
        end else begin
            state <= next_state;
            if (mc_start)
                mc_cnt <= '0;
            else if ((state == MC_RUN) && !cnt_max)
                mc_cnt <= mc_cnt + MCC_W'(1);
            if ((state == MC_RUN) && cnt_max && !mc_done)
                mc_timeout <= 1'b1;
            if (pc_stall)
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr, id_rs2_addr, exe_rd_addr;
    logic        id_rs1_is_f, id_rs2_is_f, id_use_rs1, id_use_rs2;
    logic        exe_mem_read, exe_reg_write, exe_f_reg_write, exe_is_mc, exe_br_taken;
    logic        imem_stall, dmem_stall, mc_done;
    logic        mc_start, pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, mem_wb_stall;
    logic        if_id_flush, id_exe_flush, exe_mem_bubble, mc_timeout;
    logic [31:0] perf_stall_cnt;

    int errors = 0;
    int checks = 0;
    int n_start = 0;

    hazard_stall_ctrl #(.MC_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_is_f(id_rs1_is_f), .id_rs2_is_f(id_rs2_is_f),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .exe_rd_addr(exe_rd_addr), .exe_mem_read(exe_mem_read),
        .exe_reg_write(exe_reg_write), .exe_f_reg_write(exe_f_reg_write),
        .exe_is_mc(exe_is_mc), .exe_br_taken(exe_br_taken),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .mc_done(mc_done),
        .mc_start(mc_start), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_exe_stall(id_exe_stall), .exe_mem_stall(exe_mem_stall),
        .mem_wb_stall(mem_wb_stall), .if_id_flush(if_id_flush),
        .id_exe_flush(id_exe_flush), .exe_mem_bubble(exe_mem_bubble),
        .mc_timeout(mc_timeout), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // busy: a multi-cycle op has been launched and not yet released
    // elapsed: completed waiting cycles since launch (release forced at 64)
    // held: released during a freeze, waiting for the freeze to lift
    bit          m_busy, m_held, m_to;
    int          m_elapsed;
    logic [31:0] m_perf;
    bit          e_start, e_rel, e_pc;

    function automatic bit src_hit(input logic [4:0] a, input logic f, input logic u);
        if (!u || !exe_mem_read || a != exe_rd_addr) return 0;
        if (f) return exe_f_reg_write;
        return exe_reg_write && exe_rd_addr != 0;
    endfunction

    always @(negedge clk) begin
        bit frz, lu, occ;
        bit x_st[5];
        bit x_iff, x_ief, x_bub;
        if (rst) begin
            m_busy = 0; m_held = 0; m_to = 0; m_elapsed = 0; m_perf = 0;
        end
        frz   = imem_stall || dmem_stall;
        lu    = src_hit(id_rs1_addr, id_rs1_is_f, id_use_rs1) ||
                src_hit(id_rs2_addr, id_rs2_is_f, id_use_rs2);
        e_rel = m_busy && (mc_done || m_elapsed >= 64);
        occ   = (m_busy && !e_rel) || (!m_busy && !m_held && exe_is_mc);
        e_start = !rst && !m_busy && !m_held && exe_is_mc && !frz;
        foreach (x_st[i]) x_st[i] = 0;
        x_iff = 0; x_ief = 0; x_bub = 0;
        if (!rst) begin
            if (frz) foreach (x_st[i]) x_st[i] = 1;
            else if (occ) begin x_st[0] = 1; x_st[1] = 1; x_st[2] = 1; x_bub = 1; end
            else if (exe_br_taken) begin x_iff = 1; x_ief = 1; end
            else if (lu) begin x_st[0] = 1; x_st[1] = 1; x_ief = 1; end
        end
        e_pc = x_st[0];
        chk("mc_start", mc_start, e_start);
        chk("pc_stall", pc_stall, x_st[0]);
        chk("if_id_stall", if_id_stall, x_st[1]);
        chk("id_exe_stall", id_exe_stall, x_st[2]);
        chk("exe_mem_stall", exe_mem_stall, x_st[3]);
        chk("mem_wb_stall", mem_wb_stall, x_st[4]);
        chk("if_id_flush", if_id_flush, x_iff);
        chk("id_exe_flush", id_exe_flush, x_ief);
        chk("exe_mem_bubble", exe_mem_bubble, x_bub);
        chk("mc_timeout", mc_timeout, m_to);
        chk("perf_stall_cnt", perf_stall_cnt, m_perf);
        if (mc_start === 1'b1) n_start++;
    end

    always @(posedge clk) begin
        bit frz;
        frz = imem_stall || dmem_stall;
        if (rst) begin
            m_busy = 0; m_held = 0; m_to = 0; m_elapsed = 0; m_perf = 0;
        end else begin
            if (e_start) begin
                m_busy = 1; m_elapsed = 0;
            end else if (m_busy) begin
                if (e_rel) begin
                    if (m_elapsed >= 64 && !mc_done) m_to = 1;
                    m_busy = 0; m_held = frz;
                end else m_elapsed++;
            end else if (m_held && !frz) m_held = 0;
            if (e_pc) m_perf = m_perf + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_is_f = 0; id_rs2_is_f = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; exe_rd_addr = 0; exe_mem_read = 0;
        exe_reg_write = 0; exe_f_reg_write = 0; exe_is_mc = 0; exe_br_taken = 0;
        imem_stall = 0; dmem_stall = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls, wbs, n0;
        logic [31:0] p0;
        bit rel_seen;
        rst = 1; mc_done = 0; clear_inputs();
        step(); step();
        chk("rst_pc_stall", pc_stall, 0);
        chk("rst_perf", perf_stall_cnt, 0);
        chk("rst_timeout", mc_timeout, 0);
        rst = 0;
        step();

        // T1: lw x5 in EXE, ID add x6,x5,x1
        exe_rd_addr = 5; exe_mem_read = 1; exe_reg_write = 1;
        id_rs1_addr = 5; id_rs2_addr = 1; id_use_rs1 = 1; id_use_rs2 = 1; #1;
        chk("t1_lu_pc", pc_stall, 1);
        chk("t1_lu_ifid", if_id_stall, 1);
        chk("t1_lu_flush", id_exe_flush, 1);
        step();
        exe_rd_addr = 0; exe_mem_read = 0; exe_reg_write = 0; #1;
        chk("t1_after_bubble", pc_stall, 0);
        step();
        exe_rd_addr = 0; exe_mem_read = 1; exe_reg_write = 1; id_rs1_addr = 0; #1;
        chk("t1_x0_nostall", pc_stall, 0);
        step(); clear_inputs();

        // T2: FP load-use on f0, and FP load vs integer reader
        exe_rd_addr = 0; exe_mem_read = 1; exe_f_reg_write = 1;
        id_rs1_addr = 0; id_rs1_is_f = 1; id_use_rs1 = 1; #1;
        chk("t2_f0_stall", pc_stall, 1);
        step();
        exe_rd_addr = 3; id_rs1_addr = 3; id_rs1_is_f = 0; #1;
        chk("t2_fp_vs_int", pc_stall, 0);
        step(); clear_inputs();

        // T3: fdiv, done raised six cycles after the start cycle
        exe_is_mc = 1; n0 = n_start; stalls = 0;
        for (int k = 0; k <= 6; k++) begin
            mc_done = (k == 6); #1;
            if (k == 0) chk("t3_start", mc_start, 1);
            if (pc_stall) stalls++;
            step();
        end
        chk("t3_stall_cycles", stalls, 6);
        chk("t3_start_pulses", n_start - n0, 1);
        // back-to-back mc instruction enters EXE on the release edge
        #1; chk("t3_b2b_start", mc_start, 1);

        // T4: that instruction's done coincides with a 3-cycle dmem freeze
        stalls = 1; wbs = 0;
        step();
        for (int k = 1; k <= 9; k++) begin
            mc_done = (k >= 6); dmem_stall = (k >= 6 && k <= 8); #1;
            if (pc_stall) stalls++;
            if (mem_wb_stall) wbs++;
            if (k == 9) chk("t4_release", pc_stall, 0);
            step();
        end
        chk("t4_stall_cycles", stalls, 9);
        chk("t4_freeze_cycles", wbs, 3);
        exe_is_mc = 0; #1;
        chk("t4_idle", pc_stall, 0);
        step();

        // T5: done never arrives; forced release after 64 waiting cycles
        exe_is_mc = 1; mc_done = 0; stalls = 0; rel_seen = 0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (!pc_stall) begin rel_seen = 1; break; end
            stalls++;
            step();
        end
        chk("t5_released", rel_seen, 1);
        chk("t5_stall_cycles", stalls, 65);
        step(); exe_is_mc = 0; #1;
        chk("t5_timeout_set", mc_timeout, 1);
        step(); step(); #1;
        chk("t5_timeout_sticky", mc_timeout, 1);
        // reset in the middle of MC_RUN
        exe_is_mc = 1; step(); step(); step();
        rst = 1; #1;
        chk("t5_rst_start", mc_start, 0);
        chk("t5_rst_stall", pc_stall, 0);
        chk("t5_rst_timeout", mc_timeout, 0);
        step(); exe_is_mc = 0; rst = 0; step();

        // T6: branch + load-use together, then under imem freeze
        exe_rd_addr = 5; exe_mem_read = 1; exe_reg_write = 1; exe_br_taken = 1;
        id_rs1_addr = 5; id_use_rs1 = 1; #1;
        chk("t6_flush", if_id_flush, 1);
        chk("t6_no_stall", pc_stall, 0);
        p0 = perf_stall_cnt;
        step();
        imem_stall = 1; #1;
        chk("t6_frz_noflush", id_exe_flush, 0);
        step(); step();
        imem_stall = 0; #1;
        chk("t6_flush_after", if_id_flush, 1);
        chk("t6_perf_delta", perf_stall_cnt - p0, 2);
        step(); clear_inputs(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
